// File: rtl/picoaes_pkg.sv
// rtl/picoaes_pkg.sv - shared register map, constants and types for the picoaes job master
//
// Purpose: register offsets of the picoaes slave, CTRL command words, STATUS done bit,
//          the job-master state enum, the write-data source select and a 128-bit word picker.
// Ports:   none (package).
package picoaes_pkg;

  // Register byte offsets inside the picoaes slave (word i of a 128-bit value sits
  // at the base offset minus 4*i, so word 0 is at the highest address of its group).
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_KEY0   = 8'h10;
  localparam logic [7:0] REG_PT0    = 8'h20;
  localparam logic [7:0] REG_CT0    = 8'h40;
  localparam logic [7:0] REG_STATUS = 8'h44;

  localparam logic [31:0] CTRL_INIT  = 32'h0000_0006;
  localparam logic [31:0] CTRL_START = 32'h0000_0004;

  localparam int STATUS_DONE = 0;

  typedef enum logic [2:0] {
    IDLE,
    WKEY,
    WPT,
    WCTRL,
    POLL,
    RCT,
    RESP
  } state_t;

  // Where the write data of a beat comes from.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_KEY,
    SEL_PT,
    SEL_INIT,
    SEL_START
  } wsel_t;

  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[31:0];
      2'd1:    w = v[63:32];
      2'd2:    w = v[95:64];
      default: w = v[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/picoaes_step_rom.sv
// rtl/picoaes_step_rom.sv - combinational beat table: (state, beat index) -> (wen, addr, wdata select)
//
// Purpose: describes every bus beat of a job so the master only has to walk (state, idx).
// Ports:
//   st    in  state_t     sequencer state the beat belongs to
//   idx   in  2           beat index within the state (0..3)
//   wen   out 1           1 = write beat, 0 = read beat
//   addr  out ADDR_W      byte address of the beat
//   wsel  out wsel_t      source of the write data
module picoaes_step_rom
  import picoaes_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  state_t            st,
  input  logic [1:0]        idx,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output wsel_t             wsel
);

  logic [7:0] off;
  logic [7:0] step;

  always_comb begin
    step = {4'd0, idx, 2'b00};
    wen  = 1'b0;
    off  = 8'h00;
    wsel = SEL_NONE;
    case (st)
      WKEY: begin
        wen  = 1'b1;
        off  = REG_KEY0 - step;
        wsel = SEL_KEY;
      end
      WPT: begin
        wen  = 1'b1;
        off  = REG_PT0 - step;
        wsel = SEL_PT;
      end
      WCTRL: begin
        // Two INIT writes followed by two START writes.
        wen  = 1'b1;
        off  = REG_CTRL;
        wsel = idx[1] ? SEL_START : SEL_INIT;
      end
      POLL: begin
        off = REG_STATUS;
      end
      RCT: begin
        off = REG_CT0 - step;
      end
      default: begin
      end
    endcase
  end

  assign addr = ADDR_W'(off);

endmodule

// File: rtl/picoaes_job_master.sv
// rtl/picoaes_job_master.sv - bus initiator running one picoaes encryption job end to end
//
// Purpose: accepts a (key, plaintext) job, writes key/PT and CTRL, polls STATUS, reads the
//          ciphertext back and returns it; a STATUS poll timeout returns res_err=1, res_ct=0.
// Build option: KEY_CACHE_EN - skip the key writes when the job key matches the last key written.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   job_valid/job_ready/job_key/job_pt  job input handshake and payload
//   res_valid/res_ready/res_ct/res_err  result output handshake and payload
//   m_valid/m_wen/m_addr/m_wdata      registered bus request (held until m_ready)
//   m_rdata/m_ready                   bus read data and beat completion
module picoaes_job_master
  import picoaes_pkg::*;
#(
  parameter int POLL_MAX = 255,
  parameter int ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [127:0]      job_key,
  input  logic [127:0]      job_pt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [127:0]      res_ct,
  output logic              res_err,
  output logic              m_valid,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);

  state_t            state, state_n;
  logic [1:0]        idx, idx_n;
  logic [7:0]        poll_cnt;
  logic [127:0]      key_q, pt_q;
  logic              beat_done;
  logic              accept, issue, timeout, done_ok;
  logic              poll_limit;
  logic              cache_hit;
  logic [127:0]      key_src, pt_src;
  logic              rom_wen;
  logic [ADDR_W-1:0] rom_addr;
  wsel_t             rom_wsel;
  logic [31:0]       wdata_n;

  assign beat_done = m_valid && m_ready;
  assign job_ready = (state == IDLE);
  assign res_valid = (state == RESP);

  // poll_cnt counts completed STATUS reads; the read completing now is number poll_cnt+1.
  assign poll_limit = (POLL_MAX != 0) && ((int'(poll_cnt) + 1) >= POLL_MAX);

`ifdef KEY_CACHE_EN
  logic cache_valid;
  assign cache_hit = cache_valid && (job_key == key_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cache_valid <= 1'b0;
    end else if (timeout) begin
      cache_valid <= 1'b0;
    end else if (done_ok) begin
      cache_valid <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    accept  = 1'b0;
    issue   = 1'b0;
    timeout = 1'b0;
    done_ok = 1'b0;
    case (state)
      IDLE: begin
        if (job_valid) begin
          accept  = 1'b1;
          issue   = 1'b1;
          idx_n   = 2'd0;
          state_n = cache_hit ? WPT : WKEY;
        end
      end
      WKEY, WPT, WCTRL: begin
        if (beat_done) begin
          issue = 1'b1;
          if (idx == 2'd3) begin
            idx_n = 2'd0;
            case (state)
              WKEY:    state_n = WPT;
              WPT:     state_n = WCTRL;
              default: state_n = POLL;
            endcase
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      POLL: begin
        if (beat_done) begin
          if (m_rdata[STATUS_DONE]) begin
            state_n = RCT;
            idx_n   = 2'd0;
            issue   = 1'b1;
          end else if (poll_limit) begin
            state_n = RESP;
            timeout = 1'b1;
          end else begin
            issue = 1'b1;  // same (POLL, 0) beat again
          end
        end
      end
      RCT: begin
        if (beat_done) begin
          if (idx == 2'd3) begin
            state_n = RESP;
            done_ok = 1'b1;
          end else begin
            idx_n = idx + 2'd1;
            issue = 1'b1;
          end
        end
      end
      RESP: begin
        if (res_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The beat issued at acceptance must use the incoming job, not the stale captured one.
  assign key_src = accept ? job_key : key_q;
  assign pt_src  = accept ? job_pt  : pt_q;

  picoaes_step_rom #(
    .ADDR_W(ADDR_W)
  ) u_step_rom (
    .st   (state_n),
    .idx  (idx_n),
    .wen  (rom_wen),
    .addr (rom_addr),
    .wsel (rom_wsel)
  );

  always_comb begin
    wdata_n = 32'h0;
    case (rom_wsel)
      SEL_KEY:   wdata_n = word_sel(key_src, idx_n);
      SEL_PT:    wdata_n = word_sel(pt_src, idx_n);
      SEL_INIT:  wdata_n = CTRL_INIT;
      SEL_START: wdata_n = CTRL_START;
      default:   wdata_n = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      idx      <= 2'd0;
      poll_cnt <= 8'd0;
      key_q    <= '0;
      pt_q     <= '0;
      m_valid  <= 1'b0;
      m_wen    <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= 32'h0;
      res_ct   <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;

      if (accept) begin
        key_q    <= job_key;
        pt_q     <= job_pt;
        poll_cnt <= 8'd0;
        res_ct   <= '0;
        res_err  <= 1'b0;
      end else if (state == POLL && beat_done && poll_cnt != 8'hFF) begin
        poll_cnt <= poll_cnt + 8'd1;
      end

      if (issue) begin
        m_valid <= 1'b1;
        m_wen   <= rom_wen;
        m_addr  <= rom_addr;
        m_wdata <= wdata_n;
      end else if (beat_done) begin
        m_valid <= 1'b0;
        m_wen   <= 1'b0;
        m_addr  <= '0;
        m_wdata <= 32'h0;
      end

      if (state == RCT && beat_done) begin
        res_ct[{idx, 5'b00000} +: 32] <= m_rdata;
      end

      if (timeout) begin
        res_err <= 1'b1;
        res_ct  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_picoaes_job_master.sv
// tb/tb_picoaes_job_master.sv - directed self-checking bench for picoaes_job_master
module tb_picoaes_job_master;

  localparam logic [127:0] KEY = 128'hfb0b38bcad60b76c73377dfd9ce5692f;
  localparam logic [127:0] PT1 = 128'h16b576b600a49804d81267644b80e292;
  localparam logic [127:0] CT1 = 128'h33b661a74d164dc7b811f54fe5a5832c;
  localparam logic [127:0] PT2 = 128'hfb8587bdac1c369369173bceb2ed4785;
  localparam logic [127:0] CT2 = 128'h2287d7fc410a4e2059c15b4a2a2b3375;

`ifdef KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         job_valid;
  logic         job_ready;
  logic [127:0] job_key;
  logic [127:0] job_pt;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_ct;
  logic         res_err;
  logic         m_valid;
  logic         m_wen;
  logic [23:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata = 32'h0;
  logic         m_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  // slave model state
  bit           stall_en;
  bit           stuck;
  int           busy_polls;
  int           polls = 0;
  logic [31:0]  regs [0:31];
  logic [127:0] s_ct = '0;
  bit           prev_stall = 1'b0;
  logic [57:0]  prev_beat = '0;
  logic [56:0]  log_q[$];
  logic [56:0]  exp_q[$];

  always #5 clk = ~clk;

  picoaes_job_master #(
    .POLL_MAX (4),
    .ADDR_W   (24)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_key   (job_key),
    .job_pt    (job_pt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ct    (res_ct),
    .res_err   (res_err),
    .m_valid   (m_valid),
    .m_wen     (m_wen),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lookup(input logic [127:0] k, input logic [127:0] p);
    if (k == KEY && p == PT1) return CT1;
    if (k == KEY && p == PT2) return CT2;
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [23:0] a);
    case (a)
      24'h44:  return (!stuck && polls >= busy_polls) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      24'h40:  return s_ct[31:0];
      24'h3C:  return s_ct[63:32];
      24'h38:  return s_ct[95:64];
      24'h34:  return s_ct[127:96];
      default: return 32'h0;
    endcase
  endfunction

  // Bus slave: answers and logs beats half a cycle before the completing edge.
  always @(negedge clk) begin
    if (resetn && prev_stall) begin
      chk("stall_stable", {70'h0, m_valid, m_wen, m_addr, m_wdata}, {70'h0, prev_beat});
    end
    m_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    m_rdata = slave_rd(m_addr);
    if (resetn && m_valid && m_ready) begin
      log_q.push_back({m_wen, m_addr, m_wen ? m_wdata : 32'h0});
      if (m_wen) begin
        regs[m_addr[6:2]] = m_wdata;
        if (m_addr == 24'h0 && m_wdata == 32'h4) begin
          s_ct  = lookup({regs[1], regs[2], regs[3], regs[4]}, {regs[5], regs[6], regs[7], regs[8]});
          polls = 0;
        end
      end else if (m_addr == 24'h44) begin
        polls++;
      end
    end
    prev_stall = resetn && m_valid && !m_ready;
    prev_beat  = {m_valid, m_wen, m_addr, m_wdata};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [127:0] k, input logic [127:0] p, input bit with_key,
                           input int n_polls);
    exp_q.delete();
    if (with_key)
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 24'(32'h10 - 32'(4 * i)), 32'(k >> (32 * i))});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 24'(32'h20 - 32'(4 * i)), 32'(p >> (32 * i))});
    exp_q.push_back({1'b1, 24'h0, 32'h6});
    exp_q.push_back({1'b1, 24'h0, 32'h6});
    exp_q.push_back({1'b1, 24'h0, 32'h4});
    exp_q.push_back({1'b1, 24'h0, 32'h4});
    for (int i = 0; i < n_polls; i++) exp_q.push_back({1'b0, 24'h44, 32'h0});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 24'(32'h40 - 32'(4 * i)), 32'h0});
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_beats"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
  endtask

  function automatic int count_beats(input bit wen, input logic [23:0] lo, input logic [23:0] hi);
    int n = 0;
    foreach (log_q[i])
      if (log_q[i][56] == wen && log_q[i][55:32] >= lo && log_q[i][55:32] <= hi) n++;
    return n;
  endfunction

  task automatic send_job(input logic [127:0] k, input logic [127:0] p);
    int n = 0;
    job_key   = k;
    job_pt    = p;
    job_valid = 1'b1;
    while (!job_ready && n < 100) begin
      step();
      n++;
    end
    chk("job_accept", 128'(job_ready), 128'(1));
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 2000) begin
      step();
      lat++;
    end
    chk("res_arrives", 128'(res_valid), 128'(1));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    resetn     = 1'b0;
    job_valid  = 1'b0;
    job_key    = '0;
    job_pt     = '0;
    res_ready  = 1'b0;
    stall_en   = 1'b0;
    stuck      = 1'b0;
    busy_polls = 0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_wen", 128'(m_wen), 128'(0));
    chk("rst_m_addr", 128'(m_addr), 128'(0));
    chk("rst_m_wdata", 128'(m_wdata), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_err", 128'(res_err), 128'(0));
    chk("rst_res_ct", res_ct, 128'(0));
    chk("rst_job_ready", 128'(job_ready), 128'(1));
    resetn = 1'b1;
    step();

    // job 1, no stalls, one poll
    log_q.delete();
    send_job(KEY, PT1);
    wait_res(lat);
    chk("job1_latency", 128'(lat), 128'(17));
    chk("job1_ct", res_ct, CT1);
    chk("job1_err", 128'(res_err), 128'(0));
    build_exp(KEY, PT1, 1'b1, 1);
    compare_log("job1");

    // job 2 queued while job 1 result is pending
    job_key   = KEY;
    job_pt    = PT2;
    job_valid = 1'b1;
    step();
    chk("queued_job_ready", 128'(job_ready), 128'(0));
    consume();
    log_q.delete();
    send_job(KEY, PT2);
    wait_res(lat);
    chk("job2_latency", 128'(lat), CACHE ? 128'(13) : 128'(17));
    // hold the result back for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("hold_res_valid", 128'(res_valid), 128'(1));
      chk("hold_res_ct", res_ct, CT2);
      chk("hold_job_ready", 128'(job_ready), 128'(0));
      step();
    end
    chk("job2_err", 128'(res_err), 128'(0));
    chk("job2_key_writes", 128'(count_beats(1'b1, 24'h04, 24'h10)), CACHE ? 128'(0) : 128'(4));
    build_exp(KEY, PT2, !CACHE, 1);
    compare_log("job2");
    consume();

    // STATUS never done: timeout after POLL_MAX reads
    stuck = 1'b1;
    log_q.delete();
    send_job(KEY, PT1);
    wait_res(lat);
    chk("tmo_err", 128'(res_err), 128'(1));
    chk("tmo_ct", res_ct, 128'(0));
    chk("tmo_status_reads", 128'(count_beats(1'b0, 24'h44, 24'h44)), 128'(4));
    chk("tmo_ct_reads", 128'(count_beats(1'b0, 24'h34, 24'h40)), 128'(0));
    consume();
    stuck = 1'b0;

    // random stalls, two busy polls; a timeout leaves no cached key
    stall_en   = 1'b1;
    busy_polls = 2;
    log_q.delete();
    send_job(KEY, PT1);
    wait_res(lat);
    stall_en = 1'b0;
    chk("stall_ct", res_ct, CT1);
    chk("stall_err", 128'(res_err), 128'(0));
    build_exp(KEY, PT1, 1'b1, 3);
    compare_log("stall");
    consume();

    // reset during POLL, then reissue
    busy_polls = 1000;
    send_job(KEY, PT1);
    n = 0;
    while (!(m_valid && m_addr == 24'h44) && n < 200) begin
      step();
      n++;
    end
    chk("reach_poll", 128'(m_valid && m_addr == 24'h44), 128'(1));
    resetn = 1'b0;
    step();
    chk("abort_m_valid", 128'(m_valid), 128'(0));
    chk("abort_res_valid", 128'(res_valid), 128'(0));
    chk("abort_job_ready", 128'(job_ready), 128'(1));
    resetn     = 1'b1;
    busy_polls = 0;
    step();
    log_q.delete();
    send_job(KEY, PT1);
    wait_res(lat);
    chk("reissue_latency", 128'(lat), 128'(17));
    chk("reissue_ct", res_ct, CT1);
    chk("reissue_err", 128'(res_err), 128'(0));
    build_exp(KEY, PT1, 1'b1, 1);
    compare_log("reissue");
    consume();
    chk("final_job_ready", 128'(job_ready), 128'(1));
    chk("final_res_valid", 128'(res_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
